// File: rtl/burst_grant_pkg.sv
// rtl/burst_grant_pkg.sv - shared types and constants for burst_grant_lock
// Contents: state_e (IDLE/LOCK), PKT_CNT_W (completed-packet counter width),
// idx_width() (bits needed to index n ports, never less than 1).
package burst_grant_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int PKT_CNT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_grant_lock_prio_pick.sv
// rtl/burst_grant_lock_prio_pick.sv - lowest-index-first one-hot picker with index encoder
// Ports:
//   req_i    in  NUM_PORTS  request vector, bit 0 highest priority
//   onehot_o out NUM_PORTS  lowest set bit of req_i (zero when req_i is zero)
//   idx_o    out IDX_W      index of the picked bit
//   any_o    out 1          req_i is non-zero
module prio_pick
    import burst_grant_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] onehot_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    always_comb begin
        // x & -x isolates the lowest set bit.
        onehot_o = req_i & (~req_i + NUM_PORTS'(1));
        // onehot_o has at most one bit set, so OR-ing indices is an exact encoder.
        idx_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (onehot_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/burst_grant_lock.sv
// rtl/burst_grant_lock.sv - packet-level grant lock and output mux behind a fixed-priority arbiter
// Optional feature macro: BURST_GRANT_TIMEOUT_EN (idle-owner forced release, adds timeout_o).
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i/last_i/data_i     per-port valid, end-of-packet, data (port p at [p*DATA_W +: DATA_W])
//   ready_i                 downstream accept
//   ready_o                 per-port accept, only the owner's bit can be high
//   valid_o/data_o/last_o   output beat, combinational from the locked owner's inputs
//   owner_o, busy_o         locked port index, grant-held flag
//   timeout_o               one-cycle forced-release pulse (only with BURST_GRANT_TIMEOUT_EN)
//   pkt_cnt_o               completed-packet counter, wraps
module burst_grant_lock
    import burst_grant_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        last_i,
    input  logic [NUM_PORTS*DATA_W-1:0] data_i,
    input  logic                        ready_i,
    output logic [NUM_PORTS-1:0]        ready_o,
    output logic                        valid_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        last_o,
    output logic [$clog2(NUM_PORTS)-1:0] owner_o,
    output logic                        busy_o,
`ifdef BURST_GRANT_TIMEOUT_EN
    output logic                        timeout_o,
`endif
    output logic [PKT_CNT_W-1:0]        pkt_cnt_o
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [NUM_PORTS-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    logic                   in_lock;
    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_W-1:0]      owner_data;
    logic                   xfer;

`ifdef BURST_GRANT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    prio_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_prio_pick (
        .req_i    (req_i),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Output path is combinational through the registered owner so a locked
    // port can stream one beat per cycle with no added latency.
    assign in_lock     = (state_q == LOCK);
    assign owner_valid = req_i[owner_q];
    assign owner_last  = last_i[owner_q];
    assign owner_data  = data_i[owner_q*DATA_W +: DATA_W];

    assign valid_o = in_lock & owner_valid;
    assign last_o  = in_lock & owner_last;
    assign data_o  = in_lock ? owner_data : '0;
    assign ready_o = in_lock ? (grant_q & {NUM_PORTS{ready_i}}) : '0;
    assign xfer    = valid_o & ready_i;

    assign owner_o   = owner_q;
    assign busy_o    = in_lock;
    assign pkt_cnt_o = pkt_cnt_q;
`ifdef BURST_GRANT_TIMEOUT_EN
    assign timeout_o = timeout_q;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        pkt_cnt_d = pkt_cnt_q;
`ifdef BURST_GRANT_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCK;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
`ifdef BURST_GRANT_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            LOCK: begin
                if (xfer) begin
`ifdef BURST_GRANT_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (owner_last) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    end
                end
`ifdef BURST_GRANT_TIMEOUT_EN
                // This cycle is the TIMEOUT-th idle-owner cycle: release without counting.
                else if (!owner_valid) begin
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        timeout_d = 1'b1;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            pkt_cnt_q <= '0;
`ifdef BURST_GRANT_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            pkt_cnt_q <= pkt_cnt_d;
`ifdef BURST_GRANT_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule
